// File: rtl/pe_pkg.sv
// pe_pkg: definitions shared by the PE controller and the conv3x3 datapath.
//   NUM_TAPS / WIN           : window geometry (3x3 = 9 taps)
//   DEF_DATA_W/WEIGHT_W/ACC_W: default widths of pixels, weights and results
//   mod_type_e               : one-hot mode constants shared with the controller
//   sat_to_width()           : clamp a wide signed value to a signed width
package pe_pkg;

  localparam int NUM_TAPS     = 9;
  localparam int WIN          = 3;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_WEIGHT_W = 8;
  localparam int DEF_ACC_W    = 21;

  // Widest value the saturation helper accepts.
  localparam int SAT_W = 64;

  typedef enum logic [2:0] {
    TYPE_A = 3'b001,
    TYPE_B = 3'b010,
    TYPE_C = 3'b100
  } mod_type_e;

  // Clamp x into [-2^(width-1), 2^(width-1)-1]; never wraps.
  function automatic logic signed [SAT_W-1:0] sat_to_width(
    input logic signed [SAT_W-1:0] x,
    input int                      width
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi) begin
      return hi;
    end
    if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/conv3x3_filter_if.sv
// conv3x3_filter_if: weight-load, pixel-stream and result signals of the
// conv3x3 filter.
//   master : controller / stream source side (drives weights and pixels)
//   slave  : filter side (consumes weights and pixels, drives results)
interface conv3x3_filter_if
  import pe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int ACC_W    = DEF_ACC_W
);

  logic                       weight_in_valid;
  logic [3:0]                 weight_addr;
  logic [WEIGHT_W-1:0]        weight_data;
  logic                       process_enable;
  logic                       pix_valid;
  logic [3*DATA_W-1:0]        pix_col;
  logic                       pix_last;
  logic                       out_valid;
  logic signed [ACC_W-1:0]    out_data;

  modport master (
    output weight_in_valid, weight_addr, weight_data,
    output process_enable, pix_valid, pix_col, pix_last,
    input  out_valid, out_data
  );

  modport slave (
    input  weight_in_valid, weight_addr, weight_data,
    input  process_enable, pix_valid, pix_col, pix_last,
    output out_valid, out_data
  );

endinterface

// File: rtl/conv3x3_mac.sv
// conv3x3_mac: three-stage multiply / adder-tree / saturate pipeline.
//   clk, rst  : clock and synchronous active-high reset
//   in_valid  : a complete window is presented on window/weights
//   window    : nine unsigned pixels, tap = row*3 + col
//   weights   : nine signed weights, same tap order
//   out_valid : out_data holds a fresh result for this cycle only
//   out_data  : saturated signed sum; holds its value when not valid
module conv3x3_mac
  import pe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 in_valid,
  input  logic [NUM_TAPS-1:0][DATA_W-1:0]      window,
  input  logic [NUM_TAPS-1:0][WEIGHT_W-1:0]    weights,
  output logic                                 out_valid,
  output logic signed [ACC_W-1:0]              out_data
);

  localparam int PROD_W = DATA_W + WEIGHT_W + 1;
  localparam int SUM_W  = PROD_W + 4;

  logic signed [PROD_W-1:0] prod_d [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_q [NUM_TAPS];
  logic signed [SUM_W-1:0]  row_d  [WIN];
  logic signed [SUM_W-1:0]  row_q  [WIN];
  logic signed [SUM_W-1:0]  total;
  logic signed [ACC_W-1:0]  out_d, out_q;
  logic                     v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;

  // Pixels are zero-extended by one bit so the signed multiply treats them
  // as non-negative; the valid bit travels alongside each stage.
  always_comb begin
    for (int i = 0; i < NUM_TAPS; i++) begin
      prod_d[i] = PROD_W'($signed({1'b0, window[i]})) * PROD_W'($signed(weights[i]));
    end
    v1_d = in_valid;

    for (int r = 0; r < WIN; r++) begin
      row_d[r] = SUM_W'(prod_q[r*WIN]) + SUM_W'(prod_q[r*WIN+1]) + SUM_W'(prod_q[r*WIN+2]);
    end
    v2_d = v1_q;

    total = row_q[0] + row_q[1] + row_q[2];
    out_d = v2_q ? ACC_W'(sat_to_width(SAT_W'(total), ACC_W)) : out_q;
    v3_d  = v2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        prod_q[i] <= '0;
      end
      for (int r = 0; r < WIN; r++) begin
        row_q[r] <= '0;
      end
      out_q <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        prod_q[i] <= prod_d[i];
      end
      for (int r = 0; r < WIN; r++) begin
        row_q[r] <= row_d[r];
      end
      out_q <= out_d;
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
    end
  end

  assign out_valid = v3_q;
  assign out_data  = out_q;

endmodule

// File: rtl/conv3x3_filter.sv
// conv3x3_filter: 3x3 convolution PE datapath.
//   clk, rst : clock and synchronous active-high reset
//   bus      : conv3x3_filter_if slave port
//              weight_in_valid/weight_addr/weight_data : weight file writes
//              process_enable/pix_valid/pix_col/pix_last : column stream
//              out_valid/out_data : one saturated sum per complete window
// Holds the weight file, the 3-column window shift register and the fill
// counter; the arithmetic lives in conv3x3_mac.
module conv3x3_filter
  import pe_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int WEIGHT_W = DEF_WEIGHT_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic           clk,
  input  logic           rst,
  conv3x3_filter_if.slave bus
);

  logic [NUM_TAPS-1:0][WEIGHT_W-1:0] w_d, w_q;
  logic                              wr_pend_d, wr_pend_q;
  logic [3:0]                        wr_addr_d, wr_addr_q;
  logic [WEIGHT_W-1:0]               wr_data_d, wr_data_q;
  logic [NUM_TAPS-1:0][DATA_W-1:0]   win_d, win_q;
  logic [1:0]                        fill_d, fill_q;
  logic                              win_valid_d, win_valid_q;
  logic                              accept;
  logic                              mac_valid;
  logic signed [ACC_W-1:0]           mac_data;

  // Weight writes land one cycle late so that a window completing on the
  // same edge as a write still multiplies by the old weight.
  always_comb begin
    accept    = bus.process_enable && bus.pix_valid;

    wr_pend_d = bus.weight_in_valid && (bus.weight_addr < 4'(NUM_TAPS));
    wr_addr_d = bus.weight_addr;
    wr_data_d = bus.weight_data;
    w_d       = w_q;
    if (wr_pend_q) begin
      w_d[wr_addr_q] = wr_data_q;
    end

    win_d = win_q;
    if (accept) begin
      for (int r = 0; r < WIN; r++) begin
        win_d[r*WIN]     = win_q[r*WIN+1];
        win_d[r*WIN + 1] = win_q[r*WIN+2];
        win_d[r*WIN + 2] = bus.pix_col[r*DATA_W +: DATA_W];
      end
    end

    // Complete when this beat brings fill to 3 or fill is already 3.
    win_valid_d = accept && (fill_q >= 2'd2);

    fill_d = fill_q;
    if (!bus.process_enable) begin
      fill_d = 2'd0;
    end else if (accept) begin
      if (bus.pix_last) begin
        fill_d = 2'd0;
      end else if (fill_q != 2'd3) begin
        fill_d = fill_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_q         <= '0;
      wr_pend_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      win_q       <= '0;
      fill_q      <= 2'd0;
      win_valid_q <= 1'b0;
    end else begin
      w_q         <= w_d;
      wr_pend_q   <= wr_pend_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      win_q       <= win_d;
      fill_q      <= fill_d;
      win_valid_q <= win_valid_d;
    end
  end

  conv3x3_mac #(
    .DATA_W   (DATA_W),
    .WEIGHT_W (WEIGHT_W),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (win_valid_q),
    .window    (win_q),
    .weights   (w_q),
    .out_valid (mac_valid),
    .out_data  (mac_data)
  );

  assign bus.out_valid = mac_valid;
  assign bus.out_data  = mac_data;

endmodule

// File: tb/tb_conv3x3_filter.sv
// tb_conv3x3_filter: drives the same stimulus into a default-width filter
// and an ACC_W=16 filter; a reference model of the windowed sum pushes
// expected results (value and cycle) into per-DUT queues that monitors pop.
module tb_conv3x3_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv3x3_filter_if bus ();
  conv3x3_filter_if #(.ACC_W(16)) bus16 ();

  conv3x3_filter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  conv3x3_filter #(.ACC_W(16)) dut16 (
    .clk (clk),
    .rst (rst),
    .bus (bus16.slave)
  );

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  exp_t        q21[$];
  exp_t        q16[$];
  exp_t        m21, m16;
  int          wm[9];
  logic [23:0] hist[$];

  function automatic int satw(input int v, input int width);
    int hi, lo;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Plain 3x3 dot product of the last three accepted columns.
  function automatic int windowSum();
    int s;
    logic [23:0] c;
    s = 0;
    for (int col = 0; col < 3; col++) begin
      c = hist[hist.size() - 3 + col];
      for (int r = 0; r < 3; r++) begin
        s += wm[r*3 + col] * int'(c[r*8 +: 8]);
      end
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic vld, input logic last,
                               input logic [23:0] col, input logic wv,
                               input logic [3:0] wa, input logic [7:0] wd);
    int s;
    exp_t e;
    bus.process_enable   = en;   bus16.process_enable  = en;
    bus.pix_valid        = vld;  bus16.pix_valid       = vld;
    bus.pix_last         = last; bus16.pix_last        = last;
    bus.pix_col          = col;  bus16.pix_col         = col;
    bus.weight_in_valid  = wv;   bus16.weight_in_valid = wv;
    bus.weight_addr      = wa;   bus16.weight_addr     = wa;
    bus.weight_data      = wd;   bus16.weight_data     = wd;
    if (en && vld) begin
      hist.push_back(col);
      if (hist.size() > 3) void'(hist.pop_front());
      if (hist.size() == 3) begin
        s = windowSum();
        e.cyc = cyc + 4;
        e.val = satw(s, 21); q21.push_back(e);
        e.val = satw(s, 16); q16.push_back(e);
      end
      if (last) hist.delete();
    end
    if (!en) hist.delete();
    if (wv && wa < 4'd9) wm[wa] = int'($signed(wd));
    step();
  endtask

  task automatic idle(input logic en);
    applyStimulus(en, 1'b0, 1'b0, 24'd0, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic beat(input logic [23:0] col, input logic last);
    applyStimulus(1'b1, 1'b1, last, col, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic writeWeight(input logic [3:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 1'b0, 1'b0, 24'd0, 1'b1, a, d);
  endtask

  task automatic loadAll(input logic [7:0] d);
    for (int i = 0; i < 9; i++) writeWeight(4'(i), d);
  endtask

  task automatic resetStep();
    rst = 1'b1;
    bus.weight_in_valid = 1'b0; bus16.weight_in_valid = 1'b0;
    bus.pix_valid       = 1'b0; bus16.pix_valid       = 1'b0;
    bus.process_enable  = 1'b0; bus16.process_enable  = 1'b0;
    hist.delete();
    q21.delete();
    q16.delete();
    for (int i = 0; i < 9; i++) wm[i] = 0;
    step();
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.out_valid) begin
      tests++;
      if (q21.size() == 0) begin
        fails++;
        $display("[TB] FAIL out21 unexpected: got %0d at cycle %0d, required no output", $signed(bus.out_data), cyc);
      end else begin
        m21 = q21.pop_front();
        if ($signed(bus.out_data) != m21.val || cyc != m21.cyc) begin
          fails++;
          $display("[TB] FAIL out21: got %0d at cycle %0d, required %0d at cycle %0d", $signed(bus.out_data), cyc, m21.val, m21.cyc);
        end
      end
    end
    if (bus16.out_valid) begin
      tests++;
      if (q16.size() == 0) begin
        fails++;
        $display("[TB] FAIL out16 unexpected: got %0d at cycle %0d, required no output", $signed(bus16.out_data), cyc);
      end else begin
        m16 = q16.pop_front();
        if ($signed(bus16.out_data) != m16.val || cyc != m16.cyc) begin
          fails++;
          $display("[TB] FAIL out16: got %0d at cycle %0d, required %0d at cycle %0d", $signed(bus16.out_data), cyc, m16.val, m16.cyc);
        end
      end
    end
  end

  initial begin
    bus.weight_in_valid = 1'b0; bus16.weight_in_valid = 1'b0;
    bus.weight_addr     = 4'd0; bus16.weight_addr     = 4'd0;
    bus.weight_data     = 8'd0; bus16.weight_data     = 8'd0;
    bus.process_enable  = 1'b0; bus16.process_enable  = 1'b0;
    bus.pix_valid       = 1'b0; bus16.pix_valid       = 1'b0;
    bus.pix_col         = '0;   bus16.pix_col         = '0;
    bus.pix_last        = 1'b0; bus16.pix_last        = 1'b0;
    for (int i = 0; i < 9; i++) wm[i] = 0;
    step();
    resetStep();

    $display("[TB] reset state");
    checkOutput("reset out_valid", int'(bus.out_valid), 0);
    checkOutput("reset out_data", $signed(bus.out_data), 0);
    checkOutput("reset out_data16", $signed(bus16.out_data), 0);

    $display("[TB] all-ones");
    loadAll(8'd1);
    idle(1'b0);
    for (int i = 0; i < 4; i++) beat({8'd10, 8'd10, 8'd10}, 1'b0);
    for (int i = 0; i < 6; i++) idle(1'b1);
    checkOutput("hold out_data", $signed(bus.out_data), 90);

    $display("[TB] centre tap");
    for (int i = 0; i < 9; i++) writeWeight(4'(i), (i == 4) ? 8'd1 : 8'd0);
    idle(1'b0);
    beat({8'd3, 8'd2, 8'd1}, 1'b0);
    beat({8'd6, 8'd5, 8'd4}, 1'b0);
    beat({8'd9, 8'd8, 8'd7}, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    checkOutput("centre tap", $signed(bus.out_data), 5);

    $display("[TB] saturation");
    loadAll(8'h80);
    idle(1'b0);
    for (int i = 0; i < 3; i++) beat({8'd255, 8'd255, 8'd255}, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    checkOutput("sat acc16", $signed(bus16.out_data), -32768);
    checkOutput("sat acc21", $signed(bus.out_data), -293760);

    $display("[TB] row boundary");
    loadAll(8'd1);
    idle(1'b0);
    for (int i = 0; i < 5; i++) beat(24'($urandom), i == 4);
    for (int i = 0; i < 3; i++) beat(24'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    $display("[TB] enable and address filter");
    for (int i = 0; i < 9; i++) writeWeight(4'(i), 8'(i + 1));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0, 24'($urandom), 1'b0, 4'd0, 8'd0);
    writeWeight(4'd12, 8'd55);
    idle(1'b0);
    beat({8'd1, 8'd2, 8'd3}, 1'b0);
    beat({8'd4, 8'd5, 8'd6}, 1'b0);
    beat({8'd7, 8'd8, 8'd9}, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);
    // Taps (row,col): top 3,6,9 x w1..3, mid 2,5,8 x w4..6, bot 1,4,7 x w7..9.
    checkOutput("addr12 window", $signed(bus.out_data), 3+12+27 + 8+25+48 + 7+32+63);

    $display("[TB] reset mid-flight");
    loadAll(8'd2);
    idle(1'b0);
    for (int i = 0; i < 3; i++) beat({8'd50, 8'd60, 8'd70}, 1'b0);
    resetStep();
    for (int i = 0; i < 5; i++) begin
      checkOutput("post-reset out_valid", int'(bus.out_valid), 0);
      idle(1'b0);
    end
    checkOutput("post-reset out_data", $signed(bus.out_data), 0);
    for (int i = 0; i < 3; i++) beat({8'd255, 8'd255, 8'd255}, 1'b0);
    for (int i = 0; i < 5; i++) idle(1'b1);

    $display("[TB] random");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 7) == 0, 24'($urandom),
                    $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)), 8'($urandom));
    end
    for (int i = 0; i < 8; i++) idle(1'b0);

    checkOutput("pending expected21", q21.size(), 0);
    checkOutput("pending expected16", q16.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/conv3x3_filter.md
# conv3x3_filter

3×3 convolution PE datapath sitting directly downstream of the PE controller. It consumes the controller's weight-load strobe, weight address and process enable. It latches nine signed weights, then slides a 3×3 window over a column-serial pixel stream and emits one saturated, signed multiply-accumulate result per complete window through a 3-stage pipeline.

## Interface
- `DATA_W`, 8: unsigned pixel width.
- `WEIGHT_W`, 8: signed weight width.
- `ACC_W`, 21: signed output width. The default holds the full 9-tap sum without overflow.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `weight_in_valid`  in  1: weight write strobe from the controller.
- `weight_addr`  in  4: tap index 0..8; 9..15 ignored.
- `weight_data`  in  WEIGHT_W: signed weight for `weight_addr`.
- `process_enable`  in  1: pixel processing permitted.
- `pix_valid`  in  1: pixel column beat valid.
- `pix_col`  in  3*DATA_W: one column; [DATA_W-1:0] = top row, next = middle, MSBs = bottom.
- `pix_last`  in  1: last column of the current image row; qualified by `pix_valid`.
- `out_valid`  out  1: `out_data` valid for this cycle only.
- `out_data`  out  ACC_W: signed window sum.

## Operation
- **Weight file**
  - Nine registers `w[0..8]`; tap = row*3 + col. Row 0 is top; col 0 is the oldest column in the window.
  - On `weight_in_valid` with `weight_addr` ≤ 8: `w[weight_addr]` <= `weight_data`.
  - Addresses 9..15 are dropped; no other register changes.
  - A write is visible to windows entering stage 1 on the following cycle. Writes are allowed regardless of `process_enable`.
- **Accepting columns**
  - A column is accepted when `process_enable && pix_valid`.
  - An accepted column shifts the window left: the oldest column is discarded and `pix_col` enters col 2.
- **Fill counter**
  - Range 0..3, saturating at 3. It increments on each accepted column.
  - A window is complete on an accepted beat that brings fill to 3, or arrives with fill already 3.
- **`pix_last`**
  - On an accepted beat with `pix_last`, that beat is processed normally; it emits if it completes a window.
  - Fill is then cleared to 0, so no window spans image rows.
- **`process_enable` low**
  - Columns are ignored and fill is held at 0.
  - Window contents are stale but unused.
  - The pipeline still drains in-flight windows.
- **Arithmetic**
  - Each pixel is zero-extended to DATA_W+1 signed bits and multiplied by the signed weight, giving a (DATA_W+WEIGHT_W+1)-bit product.
  - Sums are full precision internally (+4 bits).
  - The final sum saturates to the signed ACC_W range: clamp to 2^(ACC_W-1)-1 or −2^(ACC_W-1). There is no wrap.
- **Reset**: window, fill, weights, pipeline valids, `out_valid` and `out_data` all clear to 0.

## Timing
- **Stage pipeline**
  - Stage 1: nine products registered.
  - Stage 2: three row sums registered.
  - Stage 3: final sum plus saturation, registered to `out_data`.
- **Latency**: a completing column accepted at edge N gives `out_valid` high in the cycle after edge N+3. That is 3 cycles, fixed, with no stalls.
- **Throughput**: one result per cycle, with no back-pressure on either side.
- **`out_data` when not valid**: holds its last value.
- **Reset mid-stream**: `rst` sampled high at an edge kills all in-flight valids. `out_valid` is 0 on the next cycle, and no result for a pre-reset window is ever emitted.
- **Simultaneous weight write and completing beat**: the window uses the old weight; the new weight applies from the next beat.
- **`pix_last` with fill < 2**: no output is produced and fill still clears.

## Structure
- **Shared package `pe_pkg`**
  - `NUM_TAPS` = 9 and `WIN` = 3.
  - Default DATA_W/WEIGHT_W/ACC_W.
  - The one-hot mod constants (TYPE_A/B/C = 001/010/100) shared with the controller.
  - A saturate-to-width function.
- **Sub-module `conv3x3_mac`**: the weight-times-window products, adder tree and saturation, three stages. It carries the valid bit alongside the data.
- **Top**: weight file, window shift register, fill counter, accept logic.

## Test plan
- **All-ones**: load all `w` = 1, accept 3 columns of pixels 10/10/10 → one `out_valid` with 90, exactly 3 cycles after the 3rd beat. A 4th column gives 90 on the next cycle.
- **Centre tap**: `w[4]` = 1, others 0. Columns (1,2,3), (4,5,6), (7,8,9), top to bottom → 5.
- **Saturation**: ACC_W = 16, all `w` = −128, all pixels 255 → −32768. At default ACC_W the same stimulus → −293760, unclamped.
- **Row boundary**: 5 columns with `pix_last` on the 5th → 3 outputs. The next 2 columns give no output; the 3rd column gives an output.
- **Enable and address filter**: `process_enable` low while 4 columns are driven → no outputs. `weight_addr` = 12 write leaves all `w` unchanged, checked with a known window.
- **Reset mid-flight**: `rst` high 1 cycle after a completing beat → `out_valid` never asserts for that window. Afterwards `out_data` = 0 and weights are 0: all-255 pixels give 0.
